// File: rtl/quad_gpio_irq.sv
// Wishbone GPIO block: output register with set/clear/toggle aliases, direction,
// synchronised inputs and a W1C edge-interrupt status register.
module quad_gpio_irq #(
  parameter int               WIDTH       = 8,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] OUT_RESET   = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [31:0]      i_wb_addr,
  input  logic [31:0]      i_wb_dat,
  input  logic             i_wb_we,
  input  logic             i_wb_cyc,
  output logic [31:0]      o_wb_dat,
  output logic             o_wb_ack,
  input  logic [WIDTH-1:0] i_gpio,
  output logic [WIDTH-1:0] o_gpio,
  output logic [WIDTH-1:0] o_gpio_oe,
  output logic             o_irq
);

  localparam logic [3:0] A_OUT    = 4'h0;
  localparam logic [3:0] A_SET    = 4'h1;
  localparam logic [3:0] A_CLR    = 4'h2;
  localparam logic [3:0] A_TGL    = 4'h3;
  localparam logic [3:0] A_DIR    = 4'h4;
  localparam logic [3:0] A_IN     = 4'h5;
  localparam logic [3:0] A_RISE   = 4'h6;
  localparam logic [3:0] A_FALL   = 4'h7;
  localparam logic [3:0] A_STATUS = 4'h8;

  localparam int WARM_MAX = SYNC_STAGES + 1;
  localparam int CNT_W    = $clog2(WARM_MAX + 1);

  logic [WIDTH-1:0] out_reg, dir_reg, rise_en_reg, fall_en_reg, status_reg, prev_reg;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_reg;
  logic [CNT_W-1:0] warm_reg;
  logic             ack_reg;
  logic [31:0]      dat_reg;

  logic [WIDTH-1:0] sync, wdat, rise, fall, w1c_mask, out_next, status_next;
  logic [31:0]      rd_data;
  logic [3:0]       reg_sel;
  logic             access, wr_en, warm_done;
  logic             unused_bits;

  assign access    = i_wb_cyc & ~ack_reg;
  assign wr_en     = access & i_wb_we;
  assign reg_sel   = i_wb_addr[5:2];
  assign wdat      = i_wb_dat[WIDTH-1:0];
  assign sync      = sync_reg[SYNC_STAGES-1];
  assign warm_done = (warm_reg == CNT_W'(WARM_MAX));

  // Edges are ignored until the synchroniser and prev flop hold real pin values.
  assign rise = sync & ~prev_reg & rise_en_reg & {WIDTH{warm_done}};
  assign fall = ~sync & prev_reg & fall_en_reg & {WIDTH{warm_done}};

  assign unused_bits = ^{i_wb_addr[31:6], i_wb_addr[1:0], i_wb_dat};

  always_comb begin
    rd_data = '0;
    case (reg_sel)
      A_OUT, A_SET, A_CLR, A_TGL: rd_data[WIDTH-1:0] = out_reg;
      A_DIR:    rd_data[WIDTH-1:0] = dir_reg;
      A_IN:     rd_data[WIDTH-1:0] = sync;
      A_RISE:   rd_data[WIDTH-1:0] = rise_en_reg;
      A_FALL:   rd_data[WIDTH-1:0] = fall_en_reg;
      A_STATUS: rd_data[WIDTH-1:0] = status_reg;
      default:  rd_data = '0;
    endcase
  end

  always_comb begin
    out_next = out_reg;
    w1c_mask = '0;
    if (wr_en) begin
      case (reg_sel)
        A_OUT:    out_next = wdat;
        A_SET:    out_next = out_reg | wdat;
        A_CLR:    out_next = out_reg & ~wdat;
        A_TGL:    out_next = out_reg ^ wdat;
        A_STATUS: w1c_mask = wdat;
        default:  out_next = out_reg;
      endcase
    end
    // New edges are OR-ed in after the clear so a coincident edge keeps its bit.
    status_next = (status_reg & ~w1c_mask) | rise | fall;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      out_reg     <= OUT_RESET;
      dir_reg     <= '0;
      rise_en_reg <= '0;
      fall_en_reg <= '0;
      status_reg  <= '0;
      ack_reg     <= 1'b0;
      dat_reg     <= '0;
    end else begin
      out_reg    <= out_next;
      status_reg <= status_next;
      ack_reg    <= access;
      dat_reg    <= access ? rd_data : 32'h0;
      if (wr_en && reg_sel == A_DIR)  dir_reg     <= wdat;
      if (wr_en && reg_sel == A_RISE) rise_en_reg <= wdat;
      if (wr_en && reg_sel == A_FALL) fall_en_reg <= wdat;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_reg <= '0;
      prev_reg <= '0;
      warm_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], i_gpio};
      prev_reg <= sync;
      if (!warm_done) warm_reg <= warm_reg + 1'b1;
    end
  end

  assign o_wb_ack  = ack_reg;
  assign o_wb_dat  = dat_reg;
  assign o_gpio    = out_reg;
  assign o_gpio_oe = dir_reg;
  assign o_irq     = |status_reg;

endmodule

// File: tb/tb_quad_gpio_irq.sv
// Randomised and directed bench for quad_gpio_irq against a register-map level model.
module tb_quad_gpio_irq;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  wb_addr, wb_dat_w, wb_dat_r;
  logic         wb_we, wb_cyc, wb_ack;
  logic [W-1:0] gpio_in, gpio_out, gpio_oe;
  logic         irq;

  int vectors = 0;
  int miscompares = 0;

  logic [W-1:0] m_out, m_dir, m_rise, m_fall, m_status, m_pins;

  quad_gpio_irq #(.WIDTH(W), .SYNC_STAGES(2), .OUT_RESET(8'h00)) dut (
    .i_clk(clk), .i_rst(rst), .i_wb_addr(wb_addr), .i_wb_dat(wb_dat_w),
    .i_wb_we(wb_we), .i_wb_cyc(wb_cyc), .o_wb_dat(wb_dat_r), .o_wb_ack(wb_ack),
    .i_gpio(gpio_in), .o_gpio(gpio_out), .o_gpio_oe(gpio_oe), .o_irq(irq)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_reset();
    m_out = '0; m_dir = '0; m_rise = '0; m_fall = '0; m_status = '0;
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d);
    case (a[5:2])
      4'h0: m_out = d[W-1:0];
      4'h1: m_out = m_out | d[W-1:0];
      4'h2: m_out = m_out & ~d[W-1:0];
      4'h3: m_out = m_out ^ d[W-1:0];
      4'h4: m_dir = d[W-1:0];
      4'h6: m_rise = d[W-1:0];
      4'h7: m_fall = d[W-1:0];
      4'h8: m_status = m_status & ~d[W-1:0];
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] r;
    r = '0;
    case (a[5:2])
      4'h0, 4'h1, 4'h2, 4'h3: r[W-1:0] = m_out;
      4'h4: r[W-1:0] = m_dir;
      4'h5: r[W-1:0] = m_pins;
      4'h6: r[W-1:0] = m_rise;
      4'h7: r[W-1:0] = m_fall;
      4'h8: r[W-1:0] = m_status;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Models pins that have been stable long enough for any edge to have been recorded.
  function automatic void model_pins(input logic [W-1:0] p);
    m_status = m_status | (p & ~m_pins & m_rise) | (~p & m_pins & m_fall);
    m_pins = p;
  endfunction

  // One bus transfer; hs = {ack on first edge, ack or data nonzero on the following edge}.
  task automatic wb_xfer(input logic [31:0] a, input logic we, input logic [31:0] d,
                         output logic [31:0] rdat, output logic [1:0] hs);
    wb_addr = a; wb_we = we; wb_dat_w = d; wb_cyc = 1'b1;
    step();
    hs[1] = wb_ack;
    rdat = wb_dat_r;
    wb_cyc = 1'b0; wb_we = 1'b0;
    step();
    hs[0] = wb_ack | (|wb_dat_r);
  endtask

  task automatic test_reset();
    logic [31:0] r; logic [1:0] hs;
    gpio_in = '0; wb_cyc = 0; wb_we = 0; wb_addr = '0; wb_dat_w = '0; rst = 1'b1;
    step(); step();
    rst = 1'b0;
    model_reset(); m_pins = '0;
    vectors++;
    if ({gpio_out, gpio_oe, irq, wb_ack, wb_dat_r} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: gpio=%h oe=%h irq=%b ack=%b dat=%h, required all 0",
               gpio_out, gpio_oe, irq, wb_ack, wb_dat_r);
    end
    for (int i = 0; i < 16; i++) begin
      wb_xfer(32'(i) << 2, 1'b0, 32'h0, r, hs);
      vectors++;
      if (hs !== 2'b10 || r !== model_read(32'(i) << 2)) begin
        miscompares++;
        $display("FAIL reset_read[%0h]: dat=%h hs=%b, required dat=%h hs=10",
                 i * 4, r, hs, model_read(32'(i) << 2));
      end
    end
  endtask

  task automatic test_set_toggle();
    logic [31:0] r; logic [1:0] hs;
    wb_xfer(32'h04, 1'b1, 32'hAA, r, hs);
    model_write(32'h04, 32'hAA);
    vectors++;
    if (hs !== 2'b10 || gpio_out !== 8'hAA) begin
      miscompares++;
      $display("FAIL set_aa: gpio=%h hs=%b, required gpio=aa hs=10", gpio_out, hs);
    end
    wb_xfer(32'h0C, 1'b1, 32'hFF, r, hs);
    model_write(32'h0C, 32'hFF);
    vectors++;
    if (hs !== 2'b10 || gpio_out !== 8'h55) begin
      miscompares++;
      $display("FAIL toggle_ff: gpio=%h hs=%b, required gpio=55 hs=10", gpio_out, hs);
    end
  endtask

  task automatic test_dir();
    logic [31:0] r; logic [1:0] hs;
    wb_xfer(32'h10, 1'b1, 32'hFFFF_FF0F, r, hs);
    model_write(32'h10, 32'hFFFF_FF0F);
    wb_xfer(32'h10, 1'b0, 32'h0, r, hs);
    vectors++;
    if (hs !== 2'b10 || gpio_oe !== 8'h0F || r !== 32'h0000_000F) begin
      miscompares++;
      $display("FAIL dir_rw: oe=%h dat=%h hs=%b, required oe=0f dat=0000000f", gpio_oe, r, hs);
    end
    wb_xfer(32'h3C, 1'b0, 32'h0, r, hs);
    vectors++;
    if (hs !== 2'b10 || r !== 32'h0) begin
      miscompares++;
      $display("FAIL unmapped_3c: dat=%h hs=%b, required 0", r, hs);
    end
  endtask

  task automatic test_random_regs();
    logic [31:0] a, d, r, exp; logic [1:0] hs; logic we;
    for (int i = 0; i < 80; i++) begin
      a  = ($urandom & 32'hFFFF_FFC3) | (32'($urandom_range(0, 15)) << 2);
      d  = $urandom;
      we = 1'($urandom_range(0, 1));
      exp = model_read(a);
      wb_xfer(a, we, d, r, hs);
      vectors++;
      if (we) begin
        model_write(a, d);
        if (hs !== 2'b10 || gpio_out !== m_out || gpio_oe !== m_dir || irq !== |m_status) begin
          miscompares++;
          $display("FAIL rand_write a=%h d=%h: gpio=%h oe=%h irq=%b hs=%b, required %h %h %b 10",
                   a, d, gpio_out, gpio_oe, irq, hs, m_out, m_dir, |m_status);
        end
      end else if (hs !== 2'b10 || r !== exp) begin
        miscompares++;
        $display("FAIL rand_read a=%h: dat=%h hs=%b, required %h 10", a, r, hs, exp);
      end
    end
  endtask

  task automatic test_sync_latency();
    logic [31:0] r; logic [1:0] hs; logic [W-1:0] np;
    wb_xfer(32'h18, 1'b1, 32'h01, r, hs); model_write(32'h18, 32'h01);
    wb_xfer(32'h1C, 1'b1, 32'h00, r, hs); model_write(32'h1C, 32'h00);
    gpio_in = m_pins & 8'hFE;
    repeat (4) step();
    model_pins(gpio_in);
    wb_xfer(32'h20, 1'b1, 32'hFF, r, hs); model_write(32'h20, 32'hFF);
    np = m_pins | 8'h01;
    gpio_in = np;
    wb_addr = 32'h14; wb_we = 1'b0; wb_cyc = 1'b1;
    step();
    vectors++;
    if (wb_ack !== 1'b1 || wb_dat_r[0] !== 1'b0 || irq !== 1'b0) begin
      miscompares++;
      $display("FAIL sync_edge1: ack=%b in0=%b irq=%b, required 1 0 0", wb_ack, wb_dat_r[0], irq);
    end
    step();
    vectors++;
    if (wb_ack !== 1'b0 || irq !== 1'b0) begin
      miscompares++;
      $display("FAIL sync_edge2: ack=%b irq=%b, required 0 0", wb_ack, irq);
    end
    step();
    vectors++;
    if (wb_ack !== 1'b1 || wb_dat_r !== 32'(np) || irq !== 1'b1) begin
      miscompares++;
      $display("FAIL sync_edge3: ack=%b in=%h irq=%b, required 1 %h 1", wb_ack, wb_dat_r, irq, np);
    end
    wb_cyc = 1'b0;
    step();
    model_pins(np);
  endtask

  task automatic test_w1c_collision();
    logic [31:0] r; logic [1:0] hs;
    gpio_in = m_pins & 8'hFE;
    repeat (4) step();
    model_pins(gpio_in);
    gpio_in = m_pins | 8'h01;
    step(); step();
    wb_addr = 32'h20; wb_we = 1'b1; wb_dat_w = 32'h01; wb_cyc = 1'b1;
    step();
    vectors++;
    if (wb_ack !== 1'b1) begin
      miscompares++;
      $display("FAIL w1c_collide_ack: ack=%b, required 1", wb_ack);
    end
    wb_cyc = 1'b0; wb_we = 1'b0;
    step();
    model_pins(gpio_in);
    wb_xfer(32'h20, 1'b0, 32'h0, r, hs);
    vectors++;
    if (r[0] !== 1'b1 || irq !== 1'b1) begin
      miscompares++;
      $display("FAIL w1c_collide: status=%h irq=%b, required bit0=1 irq=1", r, irq);
    end
    wb_xfer(32'h20, 1'b1, 32'h01, r, hs); model_write(32'h20, 32'h01);
    wb_xfer(32'h20, 1'b0, 32'h0, r, hs);
    vectors++;
    if (r !== 32'(m_status) || irq !== |m_status) begin
      miscompares++;
      $display("FAIL w1c_clear: status=%h irq=%b, required %h %b", r, irq, m_status, |m_status);
    end
  endtask

  task automatic test_random_edges();
    logic [31:0] r; logic [1:0] hs; logic [31:0] d;
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        d = $urandom; wb_xfer(32'h18, 1'b1, d, r, hs); model_write(32'h18, d);
        d = $urandom; wb_xfer(32'h1C, 1'b1, d, r, hs); model_write(32'h1C, d);
      end
      if ($urandom_range(0, 3) == 0) begin
        d = $urandom; wb_xfer(32'h20, 1'b1, d, r, hs); model_write(32'h20, d);
      end
      gpio_in = W'($urandom);
      repeat (4) step();
      model_pins(gpio_in);
      wb_xfer(32'h20, 1'b0, 32'h0, r, hs);
      vectors++;
      if (hs !== 2'b10 || r !== 32'(m_status) || irq !== |m_status) begin
        miscompares++;
        $display("FAIL rand_edge[%0d] pins=%h: status=%h irq=%b, required %h %b",
                 i, m_pins, r, irq, m_status, |m_status);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic exp_ack;
    wb_addr = 32'h00; wb_we = 1'b0; wb_cyc = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      exp_ack = (i % 2 == 0);
      vectors++;
      if (wb_ack !== exp_ack || wb_dat_r !== (exp_ack ? 32'(m_out) : 32'h0)) begin
        miscompares++;
        $display("FAIL back_to_back[%0d]: ack=%b dat=%h, required %b %h",
                 i, wb_ack, wb_dat_r, exp_ack, exp_ack ? 32'(m_out) : 32'h0);
      end
    end
    wb_cyc = 1'b0;
    step();
  endtask

  task automatic test_warmup();
    logic [31:0] r; logic [1:0] hs;
    gpio_in = 8'hFF; rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset(); m_pins = 8'hFF;
    wb_xfer(32'h18, 1'b1, 32'hFF, r, hs); model_write(32'h18, 32'hFF);
    repeat (6) step();
    wb_xfer(32'h20, 1'b0, 32'h0, r, hs);
    vectors++;
    if (r !== 32'h0 || irq !== 1'b0) begin
      miscompares++;
      $display("FAIL warmup: status=%h irq=%b, required 0 0", r, irq);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r; logic [1:0] hs;
    wb_xfer(32'h00, 1'b1, 32'h3C, r, hs); model_write(32'h00, 32'h3C);
    wb_xfer(32'h10, 1'b1, 32'hF0, r, hs); model_write(32'h10, 32'hF0);
    wb_addr = 32'h00; wb_we = 1'b1; wb_dat_w = 32'h99; wb_cyc = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    vectors++;
    if (wb_ack !== 1'b0 || gpio_out !== 8'h00 || gpio_oe !== 8'h00 || irq !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: ack=%b gpio=%h oe=%h irq=%b, required 0 00 00 0",
               wb_ack, gpio_out, gpio_oe, irq);
    end
    step();
    model_write(32'h00, 32'h99);
    vectors++;
    if (wb_ack !== 1'b1 || gpio_out !== 8'h99) begin
      miscompares++;
      $display("FAIL reissue_ack: ack=%b gpio=%h, required 1 99", wb_ack, gpio_out);
    end
    wb_cyc = 1'b0; wb_we = 1'b0;
    repeat (3) step();
    for (int i = 4; i < 9; i++) begin
      wb_xfer(32'(i) << 2, 1'b0, 32'h0, r, hs);
      vectors++;
      if (hs !== 2'b10 || r !== model_read(32'(i) << 2)) begin
        miscompares++;
        $display("FAIL post_reset_read[%0h]: dat=%h hs=%b, required %h 10",
                 i * 4, r, hs, model_read(32'(i) << 2));
      end
    end
  endtask

  initial begin
    test_reset();
    test_set_toggle();
    test_dir();
    test_random_regs();
    test_sync_latency();
    test_w1c_collision();
    test_random_edges();
    test_back_to_back();
    test_warmup();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
